// File: rtl/mem_wb_stage.sv
// MEM and WB pipeline stages: EX/MEM and MEM/WB registers, data-memory handshake,
// writeback select, load-use / memory-wait stall generation and EX forwarding sources.
module mem_wb_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_ex,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic        MemtoReg_ex,
  input  logic [4:0]  rs1Addr_ex,
  input  logic [4:0]  rs2Addr_ex,
  output logic        stall_ex,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  rdAddr_mem,
  output logic        RegWrite_mem,
  output logic        MemRead_mem,
  output logic [31:0] RegWriteData_wb,
  output logic [4:0]  rdAddr_wb,
  output logic        RegWrite_wb,
  output logic        mem_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             mem_err_next;

  logic        valid_mem, regwrite_mem_r, memread_mem_r, memwrite_mem_r, memtoreg_mem_r;
  logic [31:0] alu_mem_r, wdata_mem_r;
  logic [4:0]  rd_mem_r;

  logic        valid_wb, regwrite_wb_r;
  logic [4:0]  rd_wb_r;
  logic [31:0] data_wb_r;

  logic memop, mem_busy, lu;

  assign memop    = valid_mem & (memread_mem_r | memwrite_mem_r);
  assign mem_busy = memop & ~dmem_ack;
  assign lu       = valid_mem & memread_mem_r & valid_ex & (rd_mem_r != 5'd0) &
                    ((rd_mem_r == rs1Addr_ex) | (rd_mem_r == rs2Addr_ex));
  // A waiting memory access already freezes EX, so the load-use bubble only applies once it completes.
  assign stall_ex = mem_busy | lu;

  // EX/MEM contents are frozen while BUSY, so memop alone keeps the request up with stable address/data.
  assign dmem_req   = memop;
  assign dmem_we    = valid_mem & memwrite_mem_r;
  assign dmem_addr  = alu_mem_r;
  assign dmem_wdata = wdata_mem_r;

  assign ALUResult_mem   = alu_mem_r;
  assign rdAddr_mem      = rd_mem_r;
  assign RegWrite_mem    = valid_mem & regwrite_mem_r;
  assign MemRead_mem     = valid_mem & memread_mem_r;
  assign RegWriteData_wb = data_wb_r;
  assign rdAddr_wb       = rd_wb_r;
  assign RegWrite_wb     = valid_wb & regwrite_wb_r;

  always_comb begin
    state_next   = state;
    count_next   = count;
    mem_err_next = mem_err;
    case (state)
      IDLE: begin
        if (mem_busy) begin
          state_next = BUSY;
          count_next = CNT_W'(1);
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          state_next = IDLE;
          count_next = '0;
        end else if (count != CNT_W'(TIMEOUT)) begin
          count_next = count + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
    if (count_next == CNT_W'(TIMEOUT)) begin
      mem_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      mem_err <= mem_err_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_mem      <= 1'b0;
      regwrite_mem_r <= 1'b0;
      memread_mem_r  <= 1'b0;
      memwrite_mem_r <= 1'b0;
      memtoreg_mem_r <= 1'b0;
      alu_mem_r      <= '0;
      wdata_mem_r    <= '0;
      rd_mem_r       <= '0;
      valid_wb       <= 1'b0;
      regwrite_wb_r  <= 1'b0;
      rd_wb_r        <= '0;
      data_wb_r      <= '0;
    end else if (mem_busy) begin
      valid_wb <= 1'b0;
    end else begin
      if (lu) begin
        valid_mem <= 1'b0;
      end else begin
        valid_mem      <= valid_ex;
        regwrite_mem_r <= RegWrite_ex;
        memread_mem_r  <= MemRead_ex;
        memwrite_mem_r <= MemWrite_ex;
        memtoreg_mem_r <= MemtoReg_ex;
        alu_mem_r      <= ALUResult_ex;
        wdata_mem_r    <= MemWriteData_ex;
        rd_mem_r       <= rdAddr_ex;
      end
      valid_wb      <= valid_mem;
      regwrite_wb_r <= regwrite_mem_r;
      rd_wb_r       <= rd_mem_r;
      data_wb_r     <= memtoreg_mem_r ? dmem_rdata : alu_mem_r;
    end
  end

endmodule
